// File: rtl/password_checker_pkg.sv
// Shared constants, FSM encodings and payload types for the FNV-1a password checker.
package password_checker_pkg;

    localparam int unsigned MAX_CHARS = 16;
    localparam int unsigned WORD_W    = 8 * MAX_CHARS;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned HASH_W    = 32;
    localparam int unsigned IDX_W     = 4;

    localparam logic [HASH_W-1:0] FNV_OFFSET = 32'h811C9DC5;
    localparam logic [HASH_W-1:0] FNV_PRIME  = 32'h01000193;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HASH = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [LEN_W-1:0]  len;
    } cand_t;

    // Lengths beyond the word capacity are treated as a full word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : l;
    endfunction

endpackage

// File: rtl/password_checker_if.sv
// Candidate stream handshake between the generator (master) and the checker (slave).
interface password_checker_if;
    import password_checker_pkg::*;

    logic              cand_valid;
    logic              cand_ready;
    logic [WORD_W-1:0] cand_word;
    logic [LEN_W-1:0]  cand_len;

    modport master (output cand_valid, output cand_word, output cand_len, input cand_ready);
    modport slave  (input cand_valid, input cand_word, input cand_len, output cand_ready);

endinterface

// File: rtl/fnv1a_step.sv
// One FNV-1a-32 round: xor in a byte, multiply by the prime, keep the low 32 bits.
module fnv1a_step
    import password_checker_pkg::*;
(
    input  logic [HASH_W-1:0] h_in,
    input  logic [7:0]        data_byte,
    output logic [HASH_W-1:0] h_out
);

    assign h_out = (h_in ^ {24'd0, data_byte}) * FNV_PRIME;

endmodule

// File: rtl/password_checker.sv
// Byte-serial FNV-1a checker: hashes accepted candidates and latches the first one matching the target.
module password_checker
    import password_checker_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [HASH_W-1:0]   target_hash,
    password_checker_if.slave   cand,
    output logic                busy,
    output logic                found,
    output logic [WORD_W-1:0]   found_word,
    output logic [LEN_W-1:0]    found_len,
    output logic [HASH_W-1:0]   checked_count
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    cand_t             cand_q;
    logic [HASH_W-1:0] target_q;
    logic [HASH_W-1:0] h_q;
    logic [HASH_W-1:0] h_next;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  pos;
    logic [7:0]        cur_byte;
    logic              accept;
    logic              last_byte;

    assign cand.cand_ready = (state_q == IDLE) & enable & ~found & ~reset;
    assign accept          = cand.cand_valid & cand.cand_ready;

    // First character sits in the highest used byte, so walk downward from len-1.
    assign pos       = IDX_W'(cand_q.len - 8'd1 - LEN_W'(idx_q));
    assign cur_byte  = cand_q.word[{pos, 3'b000} +: 8];
    assign last_byte = (LEN_W'(idx_q) == (cand_q.len - 8'd1));

    fnv1a_step u_step (
        .h_in      (h_q),
        .data_byte (cur_byte),
        .h_out     (h_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (clamp_len(cand.cand_len) == '0) ? CMP : HASH;
            HASH: if (enable && last_byte) state_d = CMP;
            CMP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q        <= '0;
            target_q      <= '0;
            h_q           <= '0;
            idx_q         <= '0;
            found         <= 1'b0;
            found_word    <= '0;
            found_len     <= '0;
            checked_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cand_q.word <= cand.cand_word;
                        cand_q.len  <= clamp_len(cand.cand_len);
                        target_q    <= target_hash;
                        h_q         <= FNV_OFFSET;
                        idx_q       <= '0;
                    end
                end
                HASH: begin
                    if (enable) begin
                        h_q   <= h_next;
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                CMP: begin
                    checked_count <= checked_count + 32'd1;
                    if (h_q == target_q) begin
                        found      <= 1'b1;
                        found_word <= cand_q.word;
                        found_len  <= cand_q.len;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_password_checker.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level FNV-1a model.
module tb_password_checker;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [31:0]  target_hash = '0;
    logic         busy;
    logic         found;
    logic [127:0] found_word;
    logic [7:0]   found_len;
    logic [31:0]  checked_count;

    int n_checks = 0;
    int n_fail   = 0;

    password_checker_if cif();

    password_checker dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .target_hash   (target_hash),
        .cand          (cif),
        .busy          (busy),
        .found         (found),
        .found_word    (found_word),
        .found_len     (found_len),
        .checked_count (checked_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fnv(input logic [127:0] w, input int l);
        logic [31:0] h;
        logic [7:0]  b;
        h = 32'h811C9DC5;
        for (int i = 0; i < l; i++) begin
            b = w[8*(l-1-i) +: 8];
            h = (h ^ {24'd0, b}) * 32'h01000193;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a candidate occupies the checker for len enabled cycles, then one compare cycle.
    logic         m_busy = 1'b0;
    int           m_rem = 0;
    logic [127:0] m_word = '0;
    logic [7:0]   m_len = '0;
    logic [31:0]  m_hash = '0;
    logic [31:0]  m_tgt = '0;
    logic         m_found = 1'b0;
    logic [127:0] m_fword = '0;
    logic [7:0]   m_flen = '0;
    logic [31:0]  m_count = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_rem <= 0; m_found <= 1'b0;
            m_fword <= '0; m_flen <= '0; m_count <= '0;
        end else if (!m_busy) begin
            if (cif.cand_valid && enable && !m_found) begin
                m_busy <= 1'b1;
                m_word <= cif.cand_word;
                m_len  <= (cif.cand_len > 8'd16) ? 8'd16 : cif.cand_len;
                m_rem  <= (cif.cand_len > 8'd16) ? 16 : int'(cif.cand_len);
                m_hash <= fnv(cif.cand_word, (cif.cand_len > 8'd16) ? 16 : int'(cif.cand_len));
                m_tgt  <= target_hash;
            end
        end else if (m_rem > 0) begin
            if (enable) m_rem <= m_rem - 1;
        end else begin
            m_busy  <= 1'b0;
            m_count <= m_count + 32'd1;
            if (m_hash == m_tgt) begin
                m_found <= 1'b1; m_fword <= m_word; m_flen <= m_len;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cand_ready", cif.cand_ready, !m_busy && enable && !m_found && !reset);
        chk("busy", busy, m_busy);
        chk("found", found, m_found);
        chk("found_word", found_word, m_fword);
        chk("found_len", found_len, m_flen);
        chk("checked_count", checked_count, m_count);
    end

    task automatic send(input logic [127:0] w, input logic [7:0] l, input logic [31:0] t,
                        input int guard, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        cif.cand_valid = 1'b1; cif.cand_word = w; cif.cand_len = l; target_hash = t;
        for (int i = 0; i < guard; i++) begin
            if (cif.cand_ready) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) @(negedge clk);
        cif.cand_valid = 1'b0;
        cif.cand_word  = {$urandom, $urandom, $urandom, $urandom};
        cif.cand_len   = 8'($urandom);
        target_hash    = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic wait_found(output int cycles);
        cycles = 0;
        while (!found && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("found_within_bound", found, 1'b1);
    endtask

    initial begin
        bit acc;
        int cyc, cyc_ref, n_acc;
        logic [31:0] tq;
        logic [127:0] w;
        logic [7:0] l;
        cif.cand_valid = 1'b0; cif.cand_word = '0; cif.cand_len = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("model_fnv_a", fnv(128'h61, 1), 32'hE40C292C);
        chk("model_fnv_abc", fnv(128'h616263, 3), 32'h1A47E90B);
        chk("model_fnv_empty", fnv(128'h0, 0), 32'h811C9DC5);

        // 1: single char, found two cycles after accept
        enable = 1'b1;
        send(128'h61, 8'd1, 32'hE40C292C, 20, acc);
        chk("t1_accept", acc, 1'b1);
        @(posedge clk); #1;
        chk("t1_found_early", found, 1'b0);
        chk("t1_ready_low", cif.cand_ready, 1'b0);
        @(posedge clk); #1;
        chk("t1_found", found, 1'b1);
        chk("t1_word", found_word, 128'h61);
        chk("t1_count", checked_count, 32'd1);

        // 2: "abc", found after 4 cycles, ready low throughout
        do_reset();
        send(128'h616263, 8'd3, 32'h1A47E90B, 20, acc);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("t2_found_timing", found, k == 4);
            if (k < 4) chk("t2_ready_low", cif.cand_ready, 1'b0);
        end
        chk("t2_len", found_len, 8'd3);

        // 3: empty candidate matches the offset basis after one cycle
        do_reset();
        send(128'h1234, 8'd0, 32'h811C9DC5, 20, acc);
        @(posedge clk); #1;
        chk("t3_found", found, 1'b1);
        chk("t3_len", found_len, 8'd0);

        // 4: stream a..z, stop at q
        do_reset();
        tq = fnv(128'h71, 1);
        n_acc = 0;
        for (int c = 8'h61; c <= 8'h7a; c++) begin
            send(128'(c), 8'd1, tq, 20, acc);
            if (acc) n_acc++;
        end
        chk("t4_accepts", 32'(n_acc), 32'd17);
        chk("t4_count", checked_count, 32'd17);
        chk("t4_word", found_word, 128'h71);

        // 5: enable stall mid-hash delays the result by exactly the stall length
        do_reset();
        tq = fnv(128'("password"), 8);
        send(128'("password"), 8'd8, tq, 20, acc);
        wait_found(cyc_ref);
        chk("t5_ref_latency", 32'(cyc_ref), 32'd9);
        do_reset();
        send(128'("password"), 8'd8, tq, 20, acc);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_found(cyc);
        chk("t5_stall_latency", 32'(cyc + 5), 32'(cyc_ref + 3));
        chk("t5_word", found_word, 128'("password"));

        // 6: reset mid-hash discards the candidate
        do_reset();
        send(128'("hello"), 8'd5, fnv(128'("hello"), 5), 20, acc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", busy, 1'b0);
        chk("t6_found", found, 1'b0);
        chk("t6_count", checked_count, 32'd0);
        send(128'("hi"), 8'd2, fnv(128'("hi"), 2), 20, acc);
        wait_found(cyc);
        chk("t6_latency", 32'(cyc), 32'd3);
        chk("t6_word", found_word, 128'("hi"));

        // Random traffic: stalls, over-long lengths, frequent matches, occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset  = ($urandom_range(99) == 0);
            enable = ($urandom_range(7) != 0);
            cif.cand_valid = $urandom_range(1);
            w = {$urandom, $urandom, $urandom, $urandom};
            l = ($urandom_range(15) == 0) ? 8'($urandom) : 8'($urandom_range(20));
            cif.cand_word = w;
            cif.cand_len  = l;
            target_hash = ($urandom_range(3) == 0) ? fnv(w, (l > 8'd16) ? 16 : int'(l)) : $urandom;
        end
        @(negedge clk);
        cif.cand_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
